lut10_rr_scheduler: RTL and testbench

//   Shares one registered divide-by-10 lookup (out = floor(in/10), range 0..25) among
//   NUM_REQ requesters, such as spectrum-band level scalers in the LED strip path.

---
 rtl/lut10_rr_scheduler_if.sv | 34 +++
 rtl/lut10_rr_scheduler.sv | 105 ++++++++++
 tb/tb_lut10_rr_scheduler.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lut10_rr_scheduler_if.sv
// Requester/response bundle for the shared divide-by-10 lookup.
// The master side is the requester/consumer pair; the slave side is the scheduler.
interface lut10_rr_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ*8-1:0] req_data;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 resp_valid;
    logic [7:0]           resp_data;
    logic [ID_W-1:0]      resp_id;
    logic                 resp_ready;

    modport master (
        output req_valid,
        output req_data,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_data,
        input  resp_id
    );

    modport slave (
        input  req_valid,
        input  req_data,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_data,
        output resp_id
    );
endinterface

// File: rtl/lut10_rr_scheduler.sv
// Round-robin scheduler sharing one registered floor(x/10) lookup among NUM_REQ
// requesters. Grant and lookup happen in the same cycle; the quotient lands in a
// one-entry output register that can be drained and refilled on the same edge.
module lut10_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    lut10_rr_scheduler_if.slave   bus
);

    localparam int DATA_W = 8;
    localparam int CW     = ID_W + 1;

    localparam logic [CW-1:0]   NREQ_C   = CW'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX = ID_W'(NUM_REQ - 1);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    // floor(x/10) as a threshold table: the quotient is the number of multiples
    // of ten that do not exceed x, so 0..9 -> 0 and 250..255 -> 25.
    function automatic logic [DATA_W-1:0] div10_lut(input logic [DATA_W-1:0] x);
        logic [4:0] q;
        q = '0;
        for (int k = 1; k <= 25; k++) begin
            if (x >= DATA_W'(10 * k)) begin
                q = 5'(k);
            end
        end
        return {3'b000, q};
    endfunction

    logic [0:0]        r_state_p1;
    logic [DATA_W-1:0] r_data_p1;
    logic [ID_W-1:0]   r_id_p1;
    logic [ID_W-1:0]   r_ptr;

    logic              w_vld_p1;
    logic              w_can_accept_p0;
    logic              w_found_p0;
    logic [ID_W-1:0]   w_idx_p0;
    logic [CW-1:0]     w_cand_p0;
    logic              w_accept_p0;
    logic [NUM_REQ-1:0] w_req_ready_p0;
    logic [DATA_W-1:0] w_sel_data_p0;
    logic [ID_W-1:0]   w_ptr_nxt_p0;

    assign w_vld_p1        = (r_state_p1 == ST_FULL);
    assign w_can_accept_p0 = ~w_vld_p1 | bus.resp_ready;

    // Stage p0: rotating priority search starting at r_ptr, wrapping mod NUM_REQ
    always_comb begin
        w_found_p0 = 1'b0;
        w_idx_p0   = '0;
        w_cand_p0  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand_p0 = {1'b0, r_ptr} + CW'(k);
            if (w_cand_p0 >= NREQ_C) begin
                w_cand_p0 = w_cand_p0 - NREQ_C;
            end
            if (!w_found_p0 && bus.req_valid[w_cand_p0[ID_W-1:0]]) begin
                w_found_p0 = 1'b1;
                w_idx_p0   = w_cand_p0[ID_W-1:0];
            end
        end
    end

    // Requests seen while rst is high are never granted.
    assign w_accept_p0   = w_found_p0 & w_can_accept_p0 & ~rst;
    assign w_sel_data_p0 = bus.req_data[int'(w_idx_p0)*DATA_W +: DATA_W];
    assign w_ptr_nxt_p0  = (w_idx_p0 == LAST_IDX) ? '0 : w_idx_p0 + 1'b1;

    // One-hot accept strobe for the granted requester, all zero otherwise
    always_comb begin
        w_req_ready_p0 = '0;
        if (w_accept_p0) begin
            w_req_ready_p0[w_idx_p0] = 1'b1;
        end
    end

    // Stage p1: output slot; a drain and a new accept on the same edge overwrite in place
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_p1 <= ST_EMPTY;
            r_data_p1  <= '0;
            r_id_p1    <= '0;
            r_ptr      <= '0;
        end else if (w_accept_p0) begin
            r_state_p1 <= ST_FULL;
            r_data_p1  <= div10_lut(w_sel_data_p0);
            r_id_p1    <= w_idx_p0;
            r_ptr      <= w_ptr_nxt_p0;
        end else if (w_vld_p1 && bus.resp_ready) begin
            r_state_p1 <= ST_EMPTY;
        end
    end

    assign bus.req_ready  = w_req_ready_p0;
    assign bus.resp_valid = w_vld_p1;
    assign bus.resp_data  = r_data_p1;
    assign bus.resp_id    = r_id_p1;

endmodule

// File: tb/tb_lut10_rr_scheduler.sv
// Directed bench for lut10_rr_scheduler. Inputs change on the falling edge,
// outputs are inspected 1ns later or on the next falling edge. Every task starts
// and ends on a falling edge.
module tb_lut10_rr_scheduler;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    lut10_rr_scheduler_if #(.NUM_REQ(4), .ID_W(2)) bus ();

    lut10_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req_valid  = 4'b1111;
        bus.req_data   = {8'd200, 8'd9, 8'd10, 8'd255};
        bus.resp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        n_total++;
        if (bus.resp_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.resp_valid);
        else n_pass++;
        n_total++;
        if (bus.resp_data !== 8'd0) $display("FAIL reset_data got %0d want 0", bus.resp_data);
        else n_pass++;
        n_total++;
        if (bus.resp_id !== 2'd0) $display("FAIL reset_id got %0d want 0", bus.resp_id);
        else n_pass++;
        n_total++;
        if (bus.req_ready !== 4'b0000) $display("FAIL reset_no_grant got %b want 0000", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_single();
        do_reset();
        bus.req_valid  = 4'b0001;
        bus.req_data   = {24'd0, 8'd99};
        bus.resp_ready = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== 4'b0001) $display("FAIL single_ready got %b want 0001", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 8'd9, 2'd0})
            $display("FAIL single_resp got v=%b d=%0d id=%0d want v=1 d=9 id=0",
                     bus.resp_valid, bus.resp_data, bus.resp_id);
        else n_pass++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        n_total++;
        if (bus.resp_valid !== 1'b0) $display("FAIL single_drain got %b want 0", bus.resp_valid);
        else n_pass++;
    endtask

    task automatic test_round_robin();
        int exp_d [5];
        exp_d = '{25, 1, 0, 20, 25};
        do_reset();
        bus.req_data   = {8'd200, 8'd9, 8'd10, 8'd255};
        bus.req_valid  = 4'b1111;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            n_total++;
            if (bus.req_ready !== 4'(1 << (k % 4)))
                $display("FAIL rr_ready[%0d] got %b want %b", k, bus.req_ready, 4'(1 << (k % 4)));
            else n_pass++;
            @(negedge clk);
            n_total++;
            if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 8'(exp_d[k]), 2'(k % 4)})
                $display("FAIL rr_resp[%0d] got v=%b d=%0d id=%0d want v=1 d=%0d id=%0d",
                         k, bus.resp_valid, bus.resp_data, bus.resp_id, exp_d[k], k % 4);
            else n_pass++;
        end
    endtask

    // Continues directly from test_round_robin: slot holds id0/25, ptr=1, all requests up.
    task automatic test_hold();
        bus.resp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_total++;
            if (bus.req_ready !== 4'b0000) $display("FAIL hold_ready[%0d] got %b want 0000", k, bus.req_ready);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 8'd25, 2'd0})
                $display("FAIL hold_resp[%0d] got v=%b d=%0d id=%0d want v=1 d=25 id=0",
                         k, bus.resp_valid, bus.resp_data, bus.resp_id);
            else n_pass++;
        end
        bus.resp_ready = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== 4'b0010) $display("FAIL hold_release_ready got %b want 0010", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 8'd1, 2'd1})
            $display("FAIL hold_release_resp got v=%b d=%0d id=%0d want v=1 d=1 id=1",
                     bus.resp_valid, bus.resp_data, bus.resp_id);
        else n_pass++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
        n_total++;
        if (bus.resp_valid !== 1'b0) $display("FAIL hold_drain got %b want 0", bus.resp_valid);
        else n_pass++;
    endtask

    // Entered with ptr=2 and an empty slot.
    task automatic test_priority();
        bus.req_data  = {8'd200, 8'd9, 8'd10, 8'd255};
        bus.req_valid = 4'b0100;
        #1;
        n_total++;
        if (bus.req_ready !== 4'b0100) $display("FAIL prio_ready2 got %b want 0100", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.resp_data, bus.resp_id} !== {8'd0, 2'd2})
            $display("FAIL prio_resp2 got d=%0d id=%0d want d=0 id=2", bus.resp_data, bus.resp_id);
        else n_pass++;
        bus.req_valid = 4'b1010;
        #1;
        n_total++;
        if (bus.req_ready !== 4'b1000) $display("FAIL prio_ready3 got %b want 1000", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.resp_data, bus.resp_id} !== {8'd20, 2'd3})
            $display("FAIL prio_resp3 got d=%0d id=%0d want d=20 id=3", bus.resp_data, bus.resp_id);
        else n_pass++;
        bus.req_valid = 4'b0010;
        #1;
        n_total++;
        if (bus.req_ready !== 4'b0010) $display("FAIL prio_ready1 got %b want 0010", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.resp_data, bus.resp_id} !== {8'd1, 2'd1})
            $display("FAIL prio_resp1 got d=%0d id=%0d want d=1 id=1", bus.resp_data, bus.resp_id);
        else n_pass++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    // Entered with ptr=2, so without a pointer reset id3 would win over id1.
    task automatic test_reset_mid();
        bus.req_data   = {8'd200, 8'd9, 8'd10, 8'd255};
        bus.req_valid  = 4'b0010;
        bus.resp_ready = 1'b0;
        @(negedge clk);
        n_total++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 8'd1, 2'd1})
            $display("FAIL rmid_pre got v=%b d=%0d id=%0d want v=1 d=1 id=1",
                     bus.resp_valid, bus.resp_data, bus.resp_id);
        else n_pass++;
        bus.req_valid = 4'b1010;
        rst = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== 4'b0000) $display("FAIL rmid_ready_in_rst got %b want 0000", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.resp_valid, bus.resp_data} !== {1'b0, 8'd0})
            $display("FAIL rmid_drop got v=%b d=%0d want v=0 d=0", bus.resp_valid, bus.resp_data);
        else n_pass++;
        rst = 1'b0;
        bus.resp_ready = 1'b1;
        #1;
        n_total++;
        if (bus.req_ready !== 4'b0010) $display("FAIL rmid_ready_after got %b want 0010", bus.req_ready);
        else n_pass++;
        @(negedge clk);
        n_total++;
        if ({bus.resp_valid, bus.resp_data, bus.resp_id} !== {1'b1, 8'd1, 2'd1})
            $display("FAIL rmid_first got v=%b d=%0d id=%0d want v=1 d=1 id=1",
                     bus.resp_valid, bus.resp_data, bus.resp_id);
        else n_pass++;
        bus.req_valid = 4'b1000;
        @(negedge clk);
        n_total++;
        if ({bus.resp_data, bus.resp_id} !== {8'd20, 2'd3})
            $display("FAIL rmid_second got d=%0d id=%0d want d=20 id=3", bus.resp_data, bus.resp_id);
        else n_pass++;
        bus.req_valid = 4'b0000;
        @(negedge clk);
    endtask

    task automatic test_sweep();
        int v;
        int cycles;
        int got;
        int exp_q[$];
        int e;
        v = 0;
        cycles = 0;
        got = 0;
        do_reset();
        while ((v < 256 || exp_q.size() > 0) && cycles < 5000) begin
            bus.resp_ready = ($urandom_range(0, 3) != 0);
            bus.req_valid  = (v < 256) ? 4'b0001 : 4'b0000;
            bus.req_data   = {24'd0, 8'(v)};
            #1;
            if (bus.resp_valid && bus.resp_ready) begin
                got++;
                n_total++;
                if (exp_q.size() == 0) begin
                    $display("FAIL sweep_extra got d=%0d want no response", bus.resp_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({bus.resp_data, bus.resp_id} !== {8'(e), 2'd0})
                        $display("FAIL sweep_data got d=%0d id=%0d want d=%0d id=0",
                                 bus.resp_data, bus.resp_id, e);
                    else n_pass++;
                end
            end
            if (bus.req_ready[0]) begin
                exp_q.push_back(v / 10);
                v++;
            end
            @(negedge clk);
            cycles++;
        end
        bus.req_valid  = 4'b0000;
        bus.resp_ready = 1'b1;
        n_total++;
        if (cycles >= 5000) $display("FAIL sweep_timeout got %0d cycles want < 5000", cycles);
        else n_pass++;
        n_total++;
        if (got !== 256) $display("FAIL sweep_count got %0d want 256", got);
        else n_pass++;
        @(negedge clk);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst = 1'b1;
        bus.req_valid  = 4'b0000;
        bus.req_data   = '0;
        bus.resp_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_round_robin();
        test_hold();
        test_priority();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
